// File: rtl/chan_we_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : chan_we_cmd_seq
//  Description : Turns toggle-marked software commands taken from the
//                channel-write-enable register word into paced channel-enable
//                RAM writes (valid/ready), with stability filtering of the
//                incoming word, a sticky overrun flag and a command counter.
//                Build option CHAN_WE_BURST_EN: when defined, the burst-length
//                field [29:23] produces multi-write bursts with an address
//                incrementer; when undefined every command is a single write.
//  Revision    : 1.0 - initial release
// ============================================================================
module chan_we_cmd_seq #(
    parameter int ADDR_W     = 9,
    parameter int STABLE_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       sw_word,
    input  logic              ch_rdy,
    output logic              ch_wr,
    output logic [ADDR_W-1:0] ch_addr,
    output logic              ch_val,
    output logic              busy,
    output logic              overrun,
    output logic [CNT_W-1:0]  cmd_count
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_ISSUE  = 2'd2;

    localparam logic [3:0]       c_STAB_LAST = 4'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [31:0]       r_w_q;
    logic [31:0]       r_w_prev;
    logic [3:0]        r_stab;
    logic              r_tog_seen;
    logic [ADDR_W-1:0] r_addr;
    logic              r_val;
    logic              r_overrun;
    logic [CNT_W-1:0]  r_cmd_count;

    logic w_tog_new;
    logic w_stable;
    logic w_settled;
    logic w_hs;
    logic w_last;

    // A pending command exists whenever the registered toggle differs from the last one consumed
    assign w_tog_new = (r_w_q[31] != r_tog_seen);
    assign w_stable  = (r_w_q == r_w_prev);
    assign w_settled = w_stable && (r_stab == c_STAB_LAST);
    assign w_hs      = (r_state == c_ST_ISSUE) && ch_rdy;

`ifdef CHAN_WE_BURST_EN
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);
    logic [6:0] r_rem;
    assign w_last = (r_rem == 7'd0);
`else
    assign w_last = 1'b1;
`endif

    // State register
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a toggle that reverts during SETTLE cancels the command
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_tog_new) w_next_state = c_ST_SETTLE;
            end
            c_ST_SETTLE: begin
                if (!w_tog_new)     w_next_state = c_ST_IDLE;
                else if (w_settled) w_next_state = c_ST_ISSUE;
            end
            c_ST_ISSUE: begin
                if (w_hs && w_last) w_next_state = c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        ch_wr = (r_state == c_ST_ISSUE);
        busy  = (r_state != c_ST_IDLE);
    end

    assign ch_addr   = r_addr;
    assign ch_val    = r_val;
    assign overrun   = r_overrun;
    assign cmd_count = r_cmd_count;

    // Input capture, stability counting, command latch and burst stepping
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_w_q       <= 32'd0;
            r_w_prev    <= 32'd0;
            r_stab      <= 4'd0;
            r_tog_seen  <= 1'b0;
            r_addr      <= '0;
            r_val       <= 1'b0;
            r_overrun   <= 1'b0;
            r_cmd_count <= '0;
`ifdef CHAN_WE_BURST_EN
            r_rem       <= 7'd0;
`endif
        end else begin
            r_w_q    <= sw_word;
            r_w_prev <= r_w_q;
            case (r_state)
                c_ST_IDLE: begin
                    r_stab <= 4'd0;
                end
                c_ST_SETTLE: begin
                    if (w_stable) r_stab <= r_stab + 4'd1;
                    else          r_stab <= 4'd0;
                    if (w_tog_new && w_settled) begin
                        r_addr      <= r_w_q[ADDR_W-1:0];
                        r_val       <= r_w_q[30];
                        r_tog_seen  <= r_w_q[31];
                        r_cmd_count <= r_cmd_count + c_CNT_ONE;
`ifdef CHAN_WE_BURST_EN
                        r_rem       <= r_w_q[29:23];
`endif
                    end
                end
                c_ST_ISSUE: begin
                    // A new toggle while busy is reported and then swallowed on exit
                    if (w_tog_new) r_overrun <= 1'b1;
                    if (w_hs) begin
                        if (w_last) begin
                            r_tog_seen <= r_w_q[31];
                        end
`ifdef CHAN_WE_BURST_EN
                        else begin
                            r_addr <= r_addr + c_ADDR_ONE;
                            r_rem  <= r_rem - 7'd1;
                        end
`endif
                    end
                end
                default: r_stab <= 4'd0;
            endcase
        end
    end

endmodule
`default_nettype wire
